// File: rtl/sha256_drv_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sha256_drv_pkg : shared state encoding and word-count constants. Rev 1.0
// -----------------------------------------------------------------------------
package sha256_drv_pkg;

  localparam int c_block_w  = 512;
  localparam int c_digest_w = 256;
  localparam int c_hw_width = 16;
  localparam int c_ld_words = 32;
  localparam int c_ft_words = 16;
  localparam int c_cnt_w    = 5;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LD_REQ    = 4'd1,
    S_LD_ACK    = 4'd2,
    S_LD_GAP    = 4'd3,
    S_WAIT_CORE = 4'd4,
    S_FT_REQ    = 4'd5,
    S_FT_ACK    = 4'd6,
    S_FT_GAP    = 4'd7,
    S_DONE      = 4'd8
  } drv_state_t;

endpackage
`default_nettype wire

// File: rtl/sha256_drv_wordsel.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sha256_drv_wordsel : picks halfword idx of a block, most significant first. Rev 1.0
// -----------------------------------------------------------------------------
module sha256_drv_wordsel
  import sha256_drv_pkg::*;
(
  input  logic [c_block_w-1:0]  block,
  input  logic [c_cnt_w-1:0]    idx,
  output logic [c_hw_width-1:0] halfword
);

  logic [c_hw_width-1:0] w_words [c_ld_words];

  for (genvar gi = 0; gi < c_ld_words; gi++) begin : g_split
    assign w_words[gi] = block[c_block_w-1-gi*c_hw_width -: c_hw_width];
  end

  assign halfword = w_words[idx];

endmodule
`default_nettype wire

// File: rtl/sha256_host_drv.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sha256_host_drv : loads a 512-bit block as 32 halfwords, fetches the 16-halfword
// digest. Optional ack watchdog via SHA256_DRV_TIMEOUT_EN. Rev 1.0
// -----------------------------------------------------------------------------
module sha256_host_drv
  import sha256_drv_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [c_block_w-1:0]  block_data,
  output logic                  load,
  output logic                  fetch,
  output logic [c_hw_width-1:0] idata,
  input  logic                  ack,
  input  logic [c_hw_width-1:0] odata,
  input  logic                  core_busy,
  input  logic                  core_done,
  output logic [c_digest_w-1:0] digest,
  output logic                  digest_valid,
  output logic                  drv_busy,
  output logic                  err
);

`ifdef SHA256_DRV_TIMEOUT_EN
  localparam bit c_tmo_en = 1'b1;
`else
  localparam bit c_tmo_en = 1'b0;
`endif
  localparam int c_tmo_w = $clog2(ACK_TIMEOUT + 1);
  localparam int c_gap_w = $clog2(GAP_CYCLES + 1);

  drv_state_t            r_state;
  logic [c_block_w-1:0]  r_block;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_gap_w-1:0]    r_gap;
  logic [c_tmo_w-1:0]    r_tmo;
  logic [c_digest_w-1:0] r_acc;
  logic                  r_err;

  logic [c_block_w-1:0]  w_sel_block;
  logic [c_cnt_w-1:0]    w_sel_idx;
  logic [c_hw_width-1:0] w_hw;
  logic                  w_tmo_hit;

  // The selector always looks one word ahead so idata is ready when load rises.
  assign w_sel_block = (r_state == S_IDLE) ? block_data : r_block;
  assign w_sel_idx   = (r_state == S_IDLE) ? '0 : r_cnt + c_cnt_w'(1);
  assign w_tmo_hit   = c_tmo_en && (r_tmo == c_tmo_w'(ACK_TIMEOUT - 1));
  assign drv_busy    = (r_state != S_IDLE);
  assign err         = c_tmo_en ? r_err : 1'b0;

  sha256_drv_wordsel u_wordsel (
    .block    (w_sel_block),
    .idx      (w_sel_idx),
    .halfword (w_hw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_block      <= '0;
      r_cnt        <= '0;
      r_gap        <= '0;
      r_tmo        <= '0;
      r_acc        <= '0;
      r_err        <= 1'b0;
      load         <= 1'b0;
      fetch        <= 1'b0;
      idata        <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      load         <= 1'b0;
      fetch        <= 1'b0;
      digest_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_block <= block_data;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            idata   <= w_hw;
            load    <= 1'b1;
            r_state <= S_LD_REQ;
          end
        end
        S_LD_REQ: begin
          r_tmo   <= '0;
          r_state <= S_LD_ACK;
        end
        S_LD_ACK: begin
          if (ack) begin
            r_state <= S_LD_GAP;
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (c_tmo_en) begin
            r_tmo <= r_tmo + c_tmo_w'(1);
          end
        end
        S_LD_GAP: begin
          if (!core_busy) begin
            if (r_cnt == c_cnt_w'(c_ld_words - 1)) begin
              r_cnt   <= '0;
              r_state <= S_WAIT_CORE;
            end else begin
              r_cnt   <= r_cnt + c_cnt_w'(1);
              idata   <= w_hw;
              load    <= 1'b1;
              r_state <= S_LD_REQ;
            end
          end
        end
        S_WAIT_CORE: begin
          if (core_done) begin
            fetch   <= 1'b1;
            r_state <= S_FT_REQ;
          end
        end
        S_FT_REQ: begin
          r_tmo   <= '0;
          r_state <= S_FT_ACK;
        end
        S_FT_ACK: begin
          if (ack) begin
            r_acc   <= {r_acc[c_digest_w-c_hw_width-1:0], odata};
            r_cnt   <= r_cnt + c_cnt_w'(1);
            r_gap   <= '0;
            r_state <= S_FT_GAP;
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (c_tmo_en) begin
            r_tmo <= r_tmo + c_tmo_w'(1);
          end
        end
        S_FT_GAP: begin
          if (r_gap == c_gap_w'(GAP_CYCLES - 1)) begin
            if (r_cnt == c_cnt_w'(c_ft_words)) begin
              digest       <= r_acc;
              digest_valid <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              fetch   <= 1'b1;
              r_state <= S_FT_REQ;
            end
          end else begin
            r_gap <= r_gap + c_gap_w'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sha256_host_drv.md
SHA256_HOST_DRV -- requirements
Module: sha256_host_drv

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 64, meaning the maximum number of cycles to wait for ack before flagging an error.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, meaning the minimum number of idle cycles after each fetch ack.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to hash block_data.
REQ-006 SHALL have port block_data, input, 512 bits: padded message block, captured on an accepted start.
REQ-007 SHALL have port load, output, 1 bit: load strobe to the SHA-256 interface.
REQ-008 SHALL have port fetch, output, 1 bit: fetch strobe to the SHA-256 interface.
REQ-009 SHALL have port idata, output, 16 bits: message halfword to the interface.
REQ-010 SHALL have port ack, input, 1 bit: interface acknowledge.
REQ-011 SHALL have port odata, input, 16 bits: interface hash halfword, valid while ack=1 during a fetch.
REQ-012 SHALL have port core_busy, input, 1 bit: core busy flag.
REQ-013 SHALL have port core_done, input, 1 bit: one-cycle pulse when the hash is ready.
REQ-014 SHALL have port digest, output, 256 bits: assembled hash.
REQ-015 SHALL have port digest_valid, output, 1 bit: one-cycle pulse when digest is final.
REQ-016 SHALL have port drv_busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port err, output, 1 bit: sticky timeout flag, cleared by the next accepted start.

Function
REQ-018 SHALL implement states IDLE, LD_REQ, LD_ACK, LD_GAP, WAIT_CORE, FT_REQ, FT_ACK, FT_GAP and DONE.
REQ-019 SHALL accept start only in IDLE; start SHALL be ignored in any other state.
REQ-020 On an accepted start SHALL latch block_data, clear the word counter and err, and move to LD_REQ.
REQ-021 LD_REQ SHALL hold load=1 for exactly 1 cycle with idata = halfword[cnt] and then move to LD_ACK.
REQ-022 Halfword order SHALL be most significant first: halfword[0] = block_data[511:496], halfword[31] = block_data[15:0].
REQ-023 idata SHALL stay stable from LD_REQ until ack is sampled high.
REQ-024 LD_ACK SHALL move to LD_GAP on ack=1.
REQ-025 LD_GAP SHALL wait until core_busy=0 for at least 1 cycle and then increment cnt.
REQ-026 From LD_GAP, cnt<31 SHALL go to LD_REQ; cnt=31 SHALL go to WAIT_CORE.
REQ-027 WAIT_CORE SHALL move to FT_REQ on core_done=1; a core_done pulse arriving in any other state SHALL be ignored.
REQ-028 FT_REQ SHALL hold fetch=1 for 1 cycle and then move to FT_ACK.
REQ-029 FT_ACK SHALL sample odata in the cycle ack=1 and write it to digest[255-16k -: 16], where k is the fetch index 0..15.
REQ-030 FT_GAP SHALL idle GAP_CYCLES cycles, then go to FT_REQ if k<15, else to DONE.
REQ-031 DONE SHALL pulse digest_valid for 1 cycle and return to IDLE.
REQ-032 digest SHALL hold its value until the next DONE.
REQ-033 load and fetch SHALL never be high in the same cycle.
REQ-034 load, fetch and digest_valid SHALL be registered outputs.
REQ-035 Total strobe count per block SHALL be exactly 32 load pulses and 16 fetch pulses.

Reset
REQ-036 On rst_n=0 SHALL asynchronously force state to IDLE and clear all counters.
REQ-037 On rst_n=0 load, fetch, digest_valid, drv_busy, err, idata and digest SHALL all be 0.
REQ-038 Reset asserted mid-block SHALL abandon the block and issue no further strobes.

Configuration
REQ-039 With SHA256_DRV_TIMEOUT_EN defined, a cycle counter SHALL run in LD_ACK and FT_ACK.
REQ-040 With SHA256_DRV_TIMEOUT_EN defined, reaching ACK_TIMEOUT cycles without ack SHALL set err=1 and return to IDLE without a digest_valid pulse.
REQ-041 Without SHA256_DRV_TIMEOUT_EN, the driver SHALL wait for ack indefinitely and err SHALL be tied to 0.

Structure
REQ-042 A shared package sha256_drv_pkg SHALL hold the state encoding, the 32/16 word-count constants and the halfword width.
REQ-043 A sub-module sha256_drv_wordsel SHALL perform the 512-to-16 halfword selection.

Verification
REQ-044 SHALL cover: "abc" padded block (61626380 00…00 00000018) -> 32 loads, 16 fetches, digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, one digest_valid pulse.
REQ-045 SHALL cover: ack delayed 10 cycles on load word 5 -> idata holds block_data[431:416] throughout and no extra load pulse is issued.
REQ-046 SHALL cover: start re-asserted while drv_busy=1 -> ignored, with strobe counts unchanged.
REQ-047 SHALL cover: rst_n low after load 12 -> outputs return to 0, and a new start issues load with halfword[0].
REQ-048 SHALL cover: SHA256_DRV_TIMEOUT_EN defined, ack withheld for 64 cycles in FT_ACK -> err=1, state IDLE, no digest_valid.
REQ-049 SHALL cover: core_busy held high for 20 cycles after load ack -> next load delayed until 1 cycle after core_busy falls.
